// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, keymap and helpers for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    SAMPLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  localparam logic [3:0] ROW_RESET = 4'b1110;
  localparam logic [3:0] COL_IDLE  = 4'b1111;

  // Indexed [row][col]
  localparam logic [3:0] KEYMAP [0:3][0:3] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Index of the lowest-numbered zero bit; bit 0 wins ties.
  function automatic logic [1:0] first_low(input logic [3:0] v);
    first_low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) first_low = 2'(i);
    end
  endfunction

endpackage

// File: rtl/col_synchronizer.sv
// rtl/col_synchronizer.sv - multi-flop synchronizer for the raw column lines
module col_synchronizer #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '1;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner with lock-on while a key is held
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DWELL_CYCLES = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_pressed
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYCLES - 1);

  logic [3:0]    col_s;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    row_q, row_d;
  logic [3:0]    code_q, code_d;
  logic          pressed_q, pressed_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [3:0]    row_next;

  col_synchronizer #(
    .WIDTH  (4),
    .STAGES (SYNC_STAGES)
  ) u_col_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (col_n),
    .q_o   (col_s)
  );

  assign row_next = {row_q[2:0], row_q[3]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    code_d    = code_q;
    pressed_d = pressed_q;
    col_idx_d = col_idx_q;
    case (state_q)
      SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SAMPLE: begin
        if (col_s != COL_IDLE) begin
          col_idx_d = first_low(col_s);
          code_d    = KEYMAP[first_low(row_q)][first_low(col_s)];
          pressed_d = 1'b1;
          state_d   = HOLD;
        end else begin
          row_d   = row_next;
          state_d = SETTLE;
        end
      end
      HOLD: begin
        // Only the latched column releases the lock; other columns are ignored.
        if (col_s[col_idx_q]) begin
          pressed_d = 1'b0;
          row_d     = row_next;
          state_d   = SETTLE;
        end
      end
      default: begin
        state_d   = SETTLE;
        row_d     = ROW_RESET;
        cnt_d     = '0;
        pressed_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SETTLE;
      cnt_q     <= '0;
      row_q     <= ROW_RESET;
      code_q    <= 4'h0;
      pressed_q <= 1'b0;
      col_idx_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      code_q    <= code_d;
      pressed_q <= pressed_d;
      col_idx_q <= col_idx_d;
    end
  end

  assign row_n       = row_q;
  assign key_code    = code_q;
  assign key_pressed = pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner
module tb_keypad_scanner;

  typedef struct packed {
    logic [3:0] code;
    logic [3:0] row;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_pressed;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  keypad_scanner #(
    .DWELL_CYCLES (4),
    .SYNC_STAGES  (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .col_n       (col_n),
    .row_n       (row_n),
    .key_code    (key_code),
    .key_pressed (key_pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical matrix: a held key at (r,c) pulls column c low while row r is driven.
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_pressed(input logic lvl, input int budget, input string name);
    int n = 0;
    while (key_pressed !== lvl && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(key_pressed), 32'(lvl));
  endtask

  task automatic press(input int r, input int c, input logic [3:0] code, input logic [3:0] row);
    exp_t e;
    e.code = code;
    e.row  = row;
    exp_q.push_back(e);
    keys[r*4+c] = 1'b1;
  endtask

  logic prev_pressed = 1'b0;
  always @(negedge clk) begin
    if (key_pressed === 1'b1 && prev_pressed === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_press: key_code=%0h row_n=%b, required no press", key_code, row_n);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("press_code", 32'(key_code), 32'(e.code));
        check("press_row", 32'(row_n), 32'(e.row));
      end
    end
    prev_pressed = key_pressed;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "timeout");
  end

  logic [3:0] rows [4];
  logic [3:0] corner_code [4];
  int corner_r [4];
  int corner_c [4];

  initial begin
    rows        = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    corner_code = '{4'h1, 4'hA, 4'hE, 4'hD};
    corner_r    = '{0, 0, 3, 3};
    corner_c    = '{0, 3, 0, 3};
    keys  = '0;
    reset = 1'b1;
    @(negedge clk);
    repeat (3) tick();
    check("reset_row_n", 32'(row_n), 32'h0000000E);
    check("reset_key_pressed", 32'(key_pressed), 32'h0);
    check("reset_key_code", 32'(key_code), 32'h0);
    reset = 1'b0;

    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("scan_row_%0d", k), 32'(row_n), 32'(rows[(k / 5) % 4]));
    end

    // Key "6"
    press(1, 2, 4'h6, 4'b1101);
    wait_pressed(1'b1, 25, "press6_detect");
    for (int k = 0; k < 6; k++) begin
      tick();
      check("press6_row_frozen", 32'(row_n), 32'h0000000D);
    end

    keys = '0;
    tick();
    check("rel6_hold_1", 32'(key_pressed), 32'h1);
    tick();
    check("rel6_hold_2", 32'(key_pressed), 32'h1);
    tick();
    check("rel6_drop", 32'(key_pressed), 32'h0);
    check("rel6_code_kept", 32'(key_code), 32'h6);
    check("rel6_row_next", 32'(row_n), 32'h0000000B);
    repeat (5) tick();
    check("rel6_scan_resume", 32'(row_n), 32'h00000007);

    // Two columns on row 3: column 1 wins
    press(3, 1, 4'h0, 4'b0111);
    keys[3*4+2] = 1'b1;
    wait_pressed(1'b1, 40, "two_col_detect");
    keys[3*4+1] = 1'b0;
    tick();
    tick();
    check("two_col_hold", 32'(key_pressed), 32'h1);
    tick();
    check("two_col_drop", 32'(key_pressed), 32'h0);
    keys = '0;
    repeat (3) tick();

    for (int i = 0; i < 4; i++) begin
      press(corner_r[i], corner_c[i], corner_code[i], rows[corner_r[i]]);
      wait_pressed(1'b1, 40, $sformatf("corner%0d_detect", i));
      keys = '0;
      wait_pressed(1'b0, 10, $sformatf("corner%0d_release", i));
      repeat (2) tick();
    end

    // Key "9" then reset mid-hold
    press(2, 2, 4'h9, 4'b1011);
    wait_pressed(1'b1, 40, "press9_detect");
    tick();
    keys  = '0;
    reset = 1'b1;
    tick();
    check("midhold_key_pressed", 32'(key_pressed), 32'h0);
    check("midhold_row_n", 32'(row_n), 32'h0000000E);
    check("midhold_key_code", 32'(key_code), 32'h0);
    reset = 1'b0;
    repeat (3) tick();

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
